// File: rtl/rs_syndrome_calc_if.sv
// Handshake and result bundle between the RS syndrome stage, its symbol source and the BM stage.
interface rs_syndrome_calc_if #(
    parameter int NSYN = 16
);
    logic                 start;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic                 busy;
    logic [NSYN*8-1:0]    syn_out;
    logic                 syn_valid;
    logic                 error_free;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, busy, syn_out, syn_valid, error_free
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, busy, syn_out, syn_valid, error_free
    );
endinterface

// File: rtl/rs_syndrome_calc.sv
// RS(255,239) syndrome stage: Horner evaluation of r(alpha^(j+FCR)) for all j in parallel,
// with optional sequential conversion of each syndrome to power (log) form.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold the last result
// S_ACCUM | taking N symbols, one Horner step per accepted symbol
// S_CONV  | power-form search, one syndrome at a time (LOG_OUT=1 only)
// S_DONE  | latch results; syn_valid pulses on the following cycle
module rs_syndrome_calc #(
    parameter int N       = 255,
    parameter int NSYN    = 16,
    parameter int FCR     = 0,
    parameter int LOG_OUT = 1
) (
    input  logic                s00_axi_aclk,
    input  logic                s00_axi_aresetn,
    rs_syndrome_calc_if.slave   bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (NSYN > 1) ? $clog2(NSYN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CONV, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_acc [NSYN];
    logic [7:0]        r_res [NSYN];
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [7:0]        r_p;
    logic [7:0]        r_k;
    logic [NSYN*8-1:0] r_syn_out;
    logic              r_syn_valid;
    logic              r_error_free;

    logic [7:0]        w_acc_next [NSYN];
    logic [NSYN*8-1:0] w_syn_pack;
    logic              w_all_zero;
    logic              w_start_ok;
    logic              w_take;
    logic              w_last_sym;
    logic [7:0]        w_cur;
    logic              w_conv_hit;
    logic              w_conv_last;
    logic [7:0]        w_conv_res;
    logic              w_in_ready;
    logic              w_busy;

    function automatic logic [7:0] gf_xalpha(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    // Constant exponent per call site, so each instance folds into a fixed XOR network.
    function automatic logic [7:0] gf_mul_pow(input logic [7:0] x, input int e);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < 255; i++)
            if (i < e) y = gf_xalpha(y);
        return y;
    endfunction

    for (genvar j = 0; j < NSYN; j++) begin : g_horner
        assign w_acc_next[j] = gf_mul_pow(r_acc[j], (j + FCR) % 255) ^ bus.in_data;
    end

    // A start coinciding with the syn_valid cycle is dropped even though the FSM is already idle.
    assign w_start_ok  = bus.start && (r_state == S_IDLE) && !r_syn_valid;
    assign w_take      = bus.in_valid && (r_state == S_ACCUM);
    assign w_last_sym  = w_take && (r_cnt == CW'(N - 1));
    assign w_cur       = r_acc[r_idx];
    assign w_conv_hit  = (w_cur == 8'h00) || (r_p == w_cur);
    assign w_conv_res  = (w_cur == 8'h00) ? 8'hFF : r_k;
    assign w_conv_last = w_conv_hit && (r_idx == IW'(NSYN - 1));

    always_comb begin
        w_syn_pack = '0;
        w_all_zero = 1'b1;
        for (int j = 0; j < NSYN; j++) begin
            w_syn_pack[8*j +: 8] = (LOG_OUT != 0) ? r_res[j] : r_acc[j];
            if (r_acc[j] != 8'h00) w_all_zero = 1'b0;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) r_state <= S_IDLE;
        else                  r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_ACCUM;
            S_ACCUM: if (w_last_sym) w_next = (LOG_OUT != 0) ? S_CONV : S_DONE;
            S_CONV:  if (w_conv_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state == S_ACCUM);
        w_busy     = (r_state != S_IDLE);
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            for (int j = 0; j < NSYN; j++) begin
                r_acc[j] <= 8'h00;
                r_res[j] <= 8'h00;
            end
            r_cnt        <= '0;
            r_idx        <= '0;
            r_p          <= 8'h01;
            r_k          <= 8'h00;
            r_syn_out    <= '0;
            r_syn_valid  <= 1'b0;
            r_error_free <= 1'b0;
        end else begin
            r_syn_valid <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        for (int j = 0; j < NSYN; j++) r_acc[j] <= 8'h00;
                        r_cnt        <= '0;
                        r_error_free <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_take) begin
                        for (int j = 0; j < NSYN; j++) r_acc[j] <= w_acc_next[j];
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_last_sym) begin
                        r_idx <= '0;
                        r_p   <= 8'h01;
                        r_k   <= 8'h00;
                    end
                end
                S_CONV: begin
                    if (w_conv_hit) begin
                        r_res[r_idx] <= w_conv_res;
                        r_idx        <= r_idx + 1'b1;
                        r_p          <= 8'h01;
                        r_k          <= 8'h00;
                    end else begin
                        r_p <= gf_xalpha(r_p);
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    r_syn_out    <= w_syn_pack;
                    r_error_free <= w_all_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.busy       = w_busy;
    assign bus.syn_out    = r_syn_out;
    assign bus.syn_valid  = r_syn_valid;
    assign bus.error_free = r_error_free;
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Scoreboard bench: two instances (power form and polynomial form) share the same stimulus;
// expected syndromes come from direct polynomial evaluation with log/antilog tables.
module tb_rs_syndrome_calc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs_syndrome_calc_if #(.NSYN(16)) if_log ();
    rs_syndrome_calc_if #(.NSYN(16)) if_poly ();

    rs_syndrome_calc #(.N(255), .NSYN(16), .FCR(0), .LOG_OUT(1)) u_log (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .bus            (if_log)
    );
    rs_syndrome_calc #(.N(255), .NSYN(16), .FCR(0), .LOG_OUT(0)) u_poly (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .bus            (if_poly)
    );

    typedef struct {
        logic [127:0] syn;
        bit           ef;
    } exp_t;

    exp_t       q_log[$];
    exp_t       q_poly[$];
    logic [7:0] cw [255];
    logic [7:0] gexp [255];
    int         glog [256];
    int         checks = 0;
    int         errors = 0;
    bit         prev_log_sv = 1'b0;
    bit         prev_poly_sv = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    // S_j = sum_i r_i * alpha^(i*j), with r_i = cw[254-i] since r_254 arrives first.
    task automatic compute(output exp_t el, output exp_t ep);
        logic [7:0] s;
        el.syn = '0;
        ep.syn = '0;
        el.ef  = 1'b1;
        for (int j = 0; j < 16; j++) begin
            s = 8'h00;
            for (int i = 0; i < 255; i++)
                s = s ^ gmul(cw[254 - i], gexp[(i * j) % 255]);
            ep.syn[8*j +: 8] = s;
            el.syn[8*j +: 8] = (s == 8'h00) ? 8'hFF : 8'(glog[s]);
            if (s != 8'h00) el.ef = 1'b0;
        end
        ep.ef = el.ef;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if_log.syn_valid) begin
            chk("log_pulse_width", 128'(prev_log_sv), 128'(0));
            if (q_log.size() == 0) begin
                checks++; errors++;
                $display("FAIL log_unexpected_syn_valid: got syn_valid=1, expected none");
            end else begin
                e = q_log.pop_front();
                chk("log_syn_out", if_log.syn_out, e.syn);
                chk("log_error_free", 128'(if_log.error_free), 128'(e.ef));
            end
        end
        if (if_poly.syn_valid) begin
            chk("poly_pulse_width", 128'(prev_poly_sv), 128'(0));
            if (q_poly.size() == 0) begin
                checks++; errors++;
                $display("FAIL poly_unexpected_syn_valid: got syn_valid=1, expected none");
            end else begin
                e = q_poly.pop_front();
                chk("poly_syn_out", if_poly.syn_out, e.syn);
                chk("poly_error_free", 128'(if_poly.error_free), 128'(e.ef));
            end
        end
        prev_log_sv  <= if_log.syn_valid;
        prev_poly_sv <= if_poly.syn_valid;
    end

    task automatic drive(input bit s, input bit v, input logic [7:0] d);
        if_log.start  = s; if_log.in_valid  = v; if_log.in_data  = d;
        if_poly.start = s; if_poly.in_valid = v; if_poly.in_data = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_log_syn_out"}, if_log.syn_out, '0);
        chk({tag, "_poly_syn_out"}, if_poly.syn_out, '0);
        chk({tag, "_log_flags"}, 128'({if_log.syn_valid, if_log.error_free, if_log.in_ready, if_log.busy}), 128'(0));
        chk({tag, "_poly_flags"}, 128'({if_poly.syn_valid, if_poly.error_free, if_poly.in_ready, if_poly.busy}), 128'(0));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((if_log.busy || if_poly.busy || if_log.syn_valid || if_poly.syn_valid) && n < 6000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 6000) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", n);
        end
        @(negedge clk);
        chk("log_queue_drained", 128'(q_log.size()), 128'(0));
        chk("poly_queue_drained", 128'(q_poly.size()), 128'(0));
    endtask

    // gap_mode: 0 back-to-back, 1 idle cycle between symbols, 2 random gaps.
    task automatic run_cw(input int gap_mode, input int start_at, input bit do_wait);
        exp_t el, ep;
        int   gaps, t;
        compute(el, ep);
        q_log.push_back(el);
        q_poly.push_back(ep);
        @(posedge clk); #1 drive(1'b1, 1'b1, 8'($urandom));
        @(posedge clk); #1 drive(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 255; i++) begin
            gaps = 0;
            if (gap_mode == 1 && i > 0) gaps = 1;
            else if (gap_mode == 2 && $urandom_range(0, 3) == 0) gaps = $urandom_range(1, 3);
            if (gaps > 0) begin
                drive(1'b0, 1'b0, 8'($urandom));
                repeat (gaps) begin @(posedge clk); #1; end
            end
            drive(i == start_at, 1'b1, cw[i]);
            t = 0;
            @(negedge clk);
            while (!if_log.in_ready && t < 10) begin
                t++;
                @(negedge clk);
            end
            if (!if_log.in_ready) begin
                checks++; errors++;
                $display("FAIL ready_timeout: got in_ready=0 at symbol %0d, expected 1", i);
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("ready_low_after_last", 128'({if_log.in_ready, if_poly.in_ready}), 128'(0));
        chk("poly_valid_not_yet", 128'(if_poly.syn_valid), 128'(0));
        @(negedge clk);
        chk("poly_valid_two_cycles", 128'(if_poly.syn_valid), 128'(1));
        if (do_wait) wait_idle();
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < 255; i++) cw[i] = (kind == 0) ? 8'h00 : 8'($urandom);
    endtask

    initial begin
        logic [8:0] x;
        x = 9'h001;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x[7:0];
            glog[x[7:0]] = i;
            x = {x[7:0], 1'b0};
            if (x[8]) x = x ^ 9'h11D;
        end
        glog[0] = 0;

        drive(1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        fill(0);
        run_cw(0, -1, 1'b1);
        chk("zero_cw_log_all_ff", if_log.syn_out, {16{8'hFF}});

        fill(0); cw[254] = 8'h01;
        run_cw(0, -1, 1'b1);
        chk("r0_error_log_zero", if_log.syn_out, '0);

        fill(0); cw[253] = 8'h01;
        run_cw(0, -1, 1'b1);
        chk("r1_error_log", if_log.syn_out, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
        chk("r1_error_poly", if_poly.syn_out, 128'h2613_87CD_E874_3A1D_8040_2010_0804_0201);

        run_cw(1, -1, 1'b1);
        chk("r1_gaps_log", if_log.syn_out, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);

        fill(1);
        run_cw(2, 100, 1'b1);

        for (int n = 0; n < 3; n++) begin
            fill(1);
            if (n == 1) for (int i = 0; i < 255; i++) if ($urandom_range(0, 7) != 0) cw[i] = 8'h00;
            run_cw(2, -1, 1'b1);
        end

        fill(0); cw[253] = 8'h01;
        run_cw(0, -1, 1'b0);
        repeat (30) @(negedge clk);
        chk("conv_running_before_reset", 128'({if_log.busy, if_log.in_ready}), 128'(2));
        rst_n = 1'b0;
        q_log.delete();
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("no_valid_after_abort", 128'({if_log.syn_valid, if_log.busy}), 128'(0));

        fill(1);
        run_cw(0, -1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
